// File: rtl/spi_host_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_host_master
//  Purpose  : Single-clock SPI master. Turns one accepted parallel command
//             (2-bit opcode + DATA_W payload) into one SS_n-framed serial
//             transaction on MOSI at one bit per clk. For op 11 (read data)
//             the reply byte is shifted in from MISO and returned on rsp_data.
//  Ports    : clk, rst_n (sync, active-low)
//             cmd_valid/cmd_ready/cmd_op/cmd_data : command handshake
//             txn_done, rsp_valid, rsp_data       : completion / read reply
//             SS_n, MOSI (registered), MISO       : serial link
//  Revision : 1.0  initial release
// ============================================================================
module spi_host_master #(
    parameter int DATA_W      = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              txn_done,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    // Serial frame: selector bit (op[1]), opcode (op[1], op[0]), payload.
    localparam int                c_FRAME_W  = DATA_W + 3;
    localparam int                c_CNT_W    = $clog2(c_FRAME_W + 16);
    localparam logic [c_CNT_W-1:0] c_LAST_TX = c_CNT_W'(c_FRAME_W - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_TA = c_CNT_W'(TURN_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_RX = c_CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SHIFT = 3'd2,
        S_TURN  = 3'd3,
        S_RECV  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_FRAME_W-1:0]   r_tx;
    logic [DATA_W-1:0]      r_rx;
    logic                   r_is_rd;
    logic                   r_ready;
    logic                   r_ss_n;
    logic                   r_mosi;
    logic                   r_done;
    logic                   r_rsp_valid;
    logic [DATA_W-1:0]      r_rsp_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_is_rd     <= 1'b0;
            r_ready     <= 1'b1;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_done      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_done      <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_ready) begin
                        r_tx    <= {cmd_op[1], cmd_op[1], cmd_op[0], cmd_data};
                        r_is_rd <= (cmd_op == 2'b11);
                        r_ready <= 1'b0;
                        r_ss_n  <= 1'b0;
                        r_mosi  <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    // First frame bit goes out on the edge leaving START.
                    r_mosi  <= r_tx[c_FRAME_W-1];
                    r_tx    <= {r_tx[c_FRAME_W-2:0], 1'b0};
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    // r_cnt indexes the bit currently on MOSI.
                    if (r_cnt == c_LAST_TX) begin
                        r_mosi <= 1'b0;
                        r_cnt  <= '0;
                        if (r_is_rd) begin
                            r_state <= S_TURN;
                        end else begin
                            r_ss_n  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_mosi <= r_tx[c_FRAME_W-1];
                        r_tx   <= {r_tx[c_FRAME_W-2:0], 1'b0};
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                S_TURN: begin
                    // The edge closing the last turnaround cycle is also the
                    // first MISO sample edge.
                    if (r_cnt == c_LAST_TA) begin
                        r_rx    <= {r_rx[DATA_W-2:0], MISO};
                        r_cnt   <= '0;
                        r_state <= S_RECV;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RECV: begin
                    // One sample was taken on entry, so DATA_W-1 remain; the
                    // final RECV edge only publishes the assembled byte.
                    if (r_cnt == c_LAST_RX) begin
                        r_rsp_data  <= r_rx;
                        r_rsp_valid <= 1'b1;
                        r_done      <= 1'b1;
                        r_ss_n      <= 1'b1;
                        r_state     <= S_GAP;
                    end else begin
                        r_rx  <= {r_rx[DATA_W-2:0], MISO};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_ss_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign txn_done  = r_done;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_host_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_host_master
//  Purpose  : Self-checking bench for spi_host_master. Three instances with
//             TURN_CYCLES = 2, 1, 4 each talk to a behavioural address/RAM
//             slave. Expected frames and replies are queued at issue time and
//             popped by a monitor whenever a DUT signals txn_done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_host_master;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] cmd_valid, cmd_ready, txn_done, rsp_valid, ss_n, mosi, miso;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] rsp_data [3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int T = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
            spi_host_master #(.DATA_W(8), .TURN_CYCLES(T)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .cmd_valid (cmd_valid[g]),
                .cmd_ready (cmd_ready[g]),
                .cmd_op    (cmd_op),
                .cmd_data  (cmd_data),
                .txn_done  (txn_done[g]),
                .rsp_valid (rsp_valid[g]),
                .rsp_data  (rsp_data[g]),
                .SS_n      (ss_n[g]),
                .MOSI      (mosi[g]),
                .MISO      (miso[g])
            );
        end
    endgenerate

    function automatic int turn_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    typedef struct {
        int         inst;
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] rsp;
        bit         chk_gap;
    } exp_t;

    exp_t q[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cycles  = 0;
    bit  done_req = 1'b0;
    bit  stim_timeout = 1'b0;
    logic rst_seen;

    always @(posedge clk) rst_seen <= rst_n;

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", nm, inst, act, exp, $time);
        end
    endtask

    // Monitor + behavioural slave. Runs on the falling edge, away from the
    // DUT's active edge.
    int         low_cnt  [3];
    int         high_cnt [3];
    logic [10:0] frm     [3];
    bit         mosi_bad [3];
    logic [1:0] cur_op   [3];
    logic [7:0] addr     [3];
    logic [7:0] ram      [3][256];
    exp_t       e;
    int         k, j, exp_len;
    logic [7:0] byte_v;

    always @(negedge clk) begin
        cycles++;
        if (cycles > 20000) begin
            chk("cycle_budget", 0, cycles, 20000);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
        for (int i = 0; i < 3; i++) begin
            if (rst_seen !== 1'b1) begin
                chk("reset_state", i,
                    {ss_n[i], mosi[i], cmd_ready[i], txn_done[i], rsp_valid[i], rsp_data[i]},
                    {5'b10100, 8'h00});
                low_cnt[i]  = 0;
                high_cnt[i] = 0;
                mosi_bad[i] = 1'b0;
                cur_op[i]   = 2'b00;
                miso[i]     = 1'b1;
            end else if (ss_n[i] == 1'b0) begin
                if (low_cnt[i] == 0 && q.size() > 0 && q[0].chk_gap && q[0].inst == i)
                    chk("gap_high_cycles", i, high_cnt[i], 2);
                k = low_cnt[i];
                low_cnt[i]++;
                if (k >= 1 && k <= 11) frm[i][11-k] = mosi[i];
                else if (mosi[i] !== 1'b0) mosi_bad[i] = 1'b1;
                if (k == 3) cur_op[i] = {frm[i][9], frm[i][8]};
                if (k == 11) begin
                    case (cur_op[i])
                        2'b00, 2'b10: addr[i] = frm[i][7:0];
                        2'b01:        ram[i][addr[i]] = frm[i][7:0];
                        default:      ;
                    endcase
                end
                // Present the reply bit for the next rising edge.
                j = k + 1 - (12 + turn_of(i));
                if (cur_op[i] == 2'b11 && j >= 0 && j < 8) begin
                    byte_v  = ram[i][addr[i]];
                    miso[i] = byte_v[7-j];
                end else begin
                    miso[i] = 1'b1;
                end
            end else begin
                if (low_cnt[i] > 0) begin
                    chk("done_at_ss_rise", i, txn_done[i], 1);
                    if (mosi[i] !== 1'b0) mosi_bad[i] = 1'b1;
                    if (txn_done[i] === 1'b1) begin
                        chk("queue_has_entry", i, q.size() > 0, 1);
                        if (q.size() > 0) begin
                            e = q.pop_front();
                            exp_len = (e.op == 2'b11) ? 20 + turn_of(i) : 12;
                            chk("instance", i, i, e.inst);
                            chk("mosi_frame", i, frm[i], {e.op[1], e.op, e.data});
                            chk("ss_low_cycles", i, low_cnt[i], exp_len);
                            chk("mosi_idle_zero", i, mosi_bad[i], 0);
                            chk("rsp_valid", i, rsp_valid[i], e.op == 2'b11);
                            if (e.op == 2'b11) chk("rsp_data", i, rsp_data[i], e.rsp);
                        end
                    end
                    low_cnt[i]  = 0;
                    mosi_bad[i] = 1'b0;
                    high_cnt[i] = 0;
                    cur_op[i]   = 2'b00;
                end else begin
                    chk("idle_quiet", i, {txn_done[i], rsp_valid[i], mosi[i]}, 0);
                end
                high_cnt[i]++;
                miso[i] = 1'b1;
            end
        end
        if (done_req) begin
            chk("queue_drained", 0, q.size(), 0);
            chk("stim_no_timeout", 0, stim_timeout, 0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    // Issue one command to instance i. Inputs change 1 ns after a rising edge.
    task automatic send(input int i, input logic [1:0] op, input logic [7:0] d,
                        input logic [7:0] r, input bit gap, input bit hold, input bit expect_done);
        logic acc;
        acc = 1'b0;
        if (expect_done) q.push_back('{i, op, d, r, gap});
        cmd_op       = op;
        cmd_data     = d;
        cmd_valid[i] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            acc = cmd_ready[i];
            @(posedge clk); #1;
            if (acc) break;
        end
        if (!acc) stim_timeout = 1'b1;
        if (!hold) cmd_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (cmd_ready[i] === 1'b1 && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) stim_timeout = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 3'b000;
        miso      = 3'b111;
        cmd_op    = 2'b00;
        cmd_data  = 8'h5A;
        // Reset hold with a pending op-00 command; accepted only after release.
        cmd_valid[0] = 1'b1;
        q.push_back('{0, 2'b00, 8'h5A, 8'h00, 1'b0});
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        wait_idle(0);

        // Full write/read loop through the slave RAM.
        send(0, 2'b00, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1);
        send(0, 2'b01, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1);
        send(0, 2'b10, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1);
        send(0, 2'b11, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_idle(0);

        // Back-to-back with cmd_valid held high.
        send(0, 2'b00, 8'h12, 8'h00, 1'b0, 1'b1, 1'b1);
        send(0, 2'b01, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1);
        wait_idle(0);
        send(0, 2'b10, 8'h12, 8'h00, 1'b0, 1'b1, 1'b1);
        send(0, 2'b11, 8'hFF, 8'h34, 1'b1, 1'b0, 1'b1);
        wait_idle(0);

        // Reset in the middle of SHIFT; the aborted frame must not complete.
        send(0, 2'b01, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(0, 2'b00, 8'hC9, 8'h00, 1'b0, 1'b0, 1'b1);
        wait_idle(0);

        // TURN_CYCLES = 1 and 4 instances reading back 0xC3.
        for (int i = 1; i < 3; i++) begin
            send(i, 2'b00, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
            send(i, 2'b01, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b1);
            send(i, 2'b10, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
            send(i, 2'b11, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b1);
            wait_idle(i);
        end

        repeat (3) @(posedge clk);
        done_req = 1'b1;
    end

endmodule
`default_nettype wire
